// File: rtl/sar_seq_pkg.sv
// ============================================================
// Module   : sar_seq_pkg
// Purpose  : Shared state encoding and width helpers for the SAR ADC sequencer.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

package sar_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CAL    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CONV   = 3'd3,
    ST_PUSH   = 3'd4
  } seq_state_e;

  localparam int RES_BITS_DEF     = 10;
  localparam int OSR_LOG2_MAX_DEF = 4;
  localparam int OUT_BITS         = RES_BITS_DEF + OSR_LOG2_MAX_DEF;

  // The accumulator of 2^osr_max results of res bits can never overflow this width.
  function automatic int out_bits(input int res, input int osr_max);
    return res + osr_max;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================
// Module   : sample_fifo
// Purpose  : Show-ahead FIFO; head is presented while not empty, drops pushes when full.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_drop
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_lw = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_lw-1:0]  r_level;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  function automatic logic [c_aw-1:0] ptr_inc(input logic [c_aw-1:0] p);
    return (p == c_aw'(DEPTH - 1)) ? '0 : p + c_aw'(1);
  endfunction

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_lw'(DEPTH));
  assign w_pop   = !w_empty && i_ready;
  // A pop frees the head slot this cycle, so a push into a full FIFO still lands.
  assign w_wr    = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rptr];
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + c_lw'(1);
        2'b01:   r_level <= r_level - c_lw'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sar_adc_sequencer.sv
// ============================================================
// Module   : sar_adc_sequencer
// Purpose  : Multi-channel SAR ADC sequencer with oversampling accumulator and sample FIFO.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module sar_adc_sequencer
  import sar_seq_pkg::*;
#(
  parameter int RES_BITS     = 10,
  parameter int CHANNELS     = 2,
  parameter int OSR_LOG2_MAX = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int CAL_CYCLES   = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                                        wb_clk_i,
  input  logic                                        nreset,
  input  logic                                        start_i,
  input  logic                                        stop_i,
  input  logic                                        continuous_i,
  input  logic                                        cal_req_i,
  input  logic [$clog2(OSR_LOG2_MAX+1)-1:0]           osr_log2_i,
  input  logic [CHANNELS-1:0]                         chan_mask_i,
  input  logic                                        clr_i,
  input  logic                                        adc_valid_i,
  input  logic [RES_BITS-1:0]                         adc_result_i,
  output logic                                        adc_en_o,
  output logic                                        adc_cal_o,
  output logic                                        adc_rstn_o,
  output logic [((CHANNELS>1)?$clog2(CHANNELS):1)-1:0] adc_chan_o,
  output logic                                        smp_valid_o,
  input  logic                                        smp_ready_i,
  output logic [RES_BITS+OSR_LOG2_MAX-1:0]            smp_data_o,
  output logic [((CHANNELS>1)?$clog2(CHANNELS):1)-1:0] smp_chan_o,
  output logic [$clog2(FIFO_DEPTH):0]                 fifo_level_o,
  output logic                                        busy_o,
  output logic                                        cal_done_o,
  output logic                                        overflow_o,
  output logic                                        timeout_o
);

  localparam int c_cw       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int c_ow       = $clog2(OSR_LOG2_MAX + 1);
  localparam int c_out_bits = out_bits(RES_BITS, OSR_LOG2_MAX);
  localparam int c_cntw     = OSR_LOG2_MAX + 1;
  localparam int c_tw       = $clog2(TIMEOUT + 1);
  localparam int c_calw     = $clog2(CAL_CYCLES + 1);

  seq_state_e r_state;
  seq_state_e w_state_next;

  logic [CHANNELS-1:0]   r_mask;
  logic [c_ow-1:0]       r_osr;
  logic                  r_cont;
  logic [c_cw-1:0]       r_chan;
  logic [c_out_bits-1:0] r_acc;
  logic [c_cntw-1:0]     r_count;
  logic [c_tw-1:0]       r_tmo;
  logic [c_calw-1:0]     r_cal_cnt;
  logic                  r_valid_prev;
  logic                  r_cal_done;
  logic                  r_overflow;
  logic                  r_timeout;

  logic                  w_adc_en;
  logic                  w_adc_cal;
  logic                  w_adc_rstn;
  logic                  w_push;
  logic                  w_accept;
  logic [c_cntw-1:0]     w_count_inc;
  logic [c_cntw-1:0]     w_target;
  logic                  w_conv_done;
  logic                  w_tmo_hit;
  logic                  w_tmo_set;
  logic                  w_cal_last;
  logic                  w_start_ok;
  logic [c_ow-1:0]       w_osr_clamped;
  logic [c_ow-1:0]       w_shamt;
  logic [c_out_bits-1:0] w_push_data;
  logic [c_cw-1:0]       w_next_chan;
  logic                  w_wrap;
  logic                  w_fifo_drop;
  logic [c_cw+c_out_bits-1:0] w_fifo_head;

  function automatic logic [c_cw-1:0] lowest_chan(input logic [CHANNELS-1:0] m);
    logic [c_cw-1:0] ch;
    ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (m[i]) ch = c_cw'(i);
    end
    return ch;
  endfunction

  // Next enabled channel above the current one; wraps to the lowest when none remains.
  always_comb begin
    w_next_chan = lowest_chan(r_mask);
    w_wrap      = 1'b1;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_chan))) begin
        w_next_chan = c_cw'(i);
        w_wrap      = 1'b0;
      end
    end
  end

  assign w_accept      = (r_state == ST_CONV) && adc_valid_i && !r_valid_prev;
  assign w_count_inc   = r_count + c_cntw'(1);
  assign w_target      = c_cntw'(1) << r_osr;
  assign w_conv_done   = w_accept && (w_count_inc == w_target);
  assign w_tmo_hit     = (r_tmo == c_tw'(TIMEOUT - 1));
  assign w_tmo_set     = (r_state == ST_CONV) && !w_accept && w_tmo_hit;
  assign w_cal_last    = (r_cal_cnt == c_calw'(CAL_CYCLES - 1));
  assign w_start_ok    = start_i && (|chan_mask_i) && !cal_req_i;
  assign w_osr_clamped = (osr_log2_i > c_ow'(OSR_LOG2_MAX)) ? c_ow'(OSR_LOG2_MAX) : osr_log2_i;
  assign w_shamt       = c_ow'(OSR_LOG2_MAX) - r_osr;
  assign w_push_data   = r_acc << w_shamt;

  always_ff @(posedge wb_clk_i or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_adc_en     = 1'b0;
    w_adc_cal    = 1'b0;
    w_adc_rstn   = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cal_req_i) begin
          w_state_next = ST_CAL;
        end else if (w_start_ok) begin
          w_state_next = ST_SETTLE;
        end
      end
      ST_CAL: begin
        w_adc_rstn = 1'b1;
        w_adc_en   = 1'b1;
        w_adc_cal  = 1'b1;
        if (w_cal_last) w_state_next = ST_IDLE;
      end
      ST_SETTLE: begin
        w_adc_rstn   = 1'b1;
        w_state_next = ST_CONV;
      end
      ST_CONV: begin
        w_adc_rstn = 1'b1;
        w_adc_en   = 1'b1;
        if (w_conv_done) begin
          w_state_next = ST_PUSH;
        end else if (w_tmo_set) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_PUSH: begin
        w_adc_rstn   = 1'b1;
        w_push       = 1'b1;
        w_state_next = (w_wrap && !r_cont) ? ST_IDLE : ST_SETTLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Abort overrides every transition; a PUSH in progress still writes via w_push.
    if (stop_i && (r_state != ST_IDLE)) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge wb_clk_i or negedge nreset) begin
    if (!nreset) begin
      r_mask       <= '0;
      r_osr        <= '0;
      r_cont       <= 1'b0;
      r_chan       <= '0;
      r_acc        <= '0;
      r_count      <= '0;
      r_tmo        <= '0;
      r_cal_cnt    <= '0;
      r_valid_prev <= 1'b0;
      r_cal_done   <= 1'b0;
      r_overflow   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_valid_prev <= adc_valid_i;
      r_cal_done   <= (r_state == ST_CAL) && w_cal_last;
      case (r_state)
        ST_IDLE: begin
          r_cal_cnt <= '0;
          if (w_start_ok) begin
            r_mask <= chan_mask_i;
            r_osr  <= w_osr_clamped;
            r_cont <= continuous_i;
            r_chan <= lowest_chan(chan_mask_i);
          end
        end
        ST_CAL: r_cal_cnt <= r_cal_cnt + c_calw'(1);
        ST_SETTLE: begin
          r_acc   <= '0;
          r_count <= '0;
          r_tmo   <= '0;
        end
        ST_CONV: begin
          if (w_accept) begin
            r_acc   <= r_acc + c_out_bits'(adc_result_i);
            r_count <= w_count_inc;
            r_tmo   <= '0;
          end else begin
            r_tmo <= r_tmo + c_tw'(1);
          end
        end
        ST_PUSH: r_chan <= w_next_chan;
        default: ;
      endcase
      if (w_tmo_set) begin
        r_timeout <= 1'b1;
      end else if (clr_i) begin
        r_timeout <= 1'b0;
      end
      if (w_fifo_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

  sample_fifo #(
    .WIDTH (c_cw + c_out_bits),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (nreset),
    .i_push  (w_push),
    .i_data  ({r_chan, w_push_data}),
    .i_ready (smp_ready_i),
    .o_valid (smp_valid_o),
    .o_data  (w_fifo_head),
    .o_level (fifo_level_o),
    .o_drop  (w_fifo_drop)
  );

  assign smp_chan_o = w_fifo_head[c_cw+c_out_bits-1:c_out_bits];
  assign smp_data_o = w_fifo_head[c_out_bits-1:0];

  assign adc_en_o   = w_adc_en;
  assign adc_cal_o  = w_adc_cal;
  assign adc_rstn_o = w_adc_rstn;
  assign adc_chan_o = r_chan;
  assign busy_o     = (r_state != ST_IDLE);
  assign cal_done_o = r_cal_done;
  assign overflow_o = r_overflow;
  assign timeout_o  = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_sar_adc_sequencer.sv
// ============================================================
// Module   : tb_sar_adc_sequencer
// Purpose  : Directed scoreboard bench for the SAR ADC sequencer.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module tb_sar_adc_sequencer;

  localparam int RES_BITS     = 10;
  localparam int CHANNELS     = 2;
  localparam int OSR_LOG2_MAX = 4;
  localparam int FIFO_DEPTH   = 8;
  localparam int CAL_CYCLES   = 16;
  localparam int TIMEOUT      = 255;
  localparam int CW = 1;
  localparam int OW = 3;
  localparam int OB = 14;
  localparam int LW = 4;

  logic wb_clk_i = 1'b0;
  logic nreset = 1'b0;
  logic start_i = 1'b0;
  logic stop_i = 1'b0;
  logic continuous_i = 1'b0;
  logic cal_req_i = 1'b0;
  logic clr_i = 1'b0;
  logic adc_valid_i = 1'b0;
  logic smp_ready_i = 1'b0;
  logic [OW-1:0]       osr_log2_i = '0;
  logic [CHANNELS-1:0] chan_mask_i = '0;
  logic [RES_BITS-1:0] adc_result_i = '0;

  logic          adc_en_o, adc_cal_o, adc_rstn_o;
  logic [CW-1:0] adc_chan_o;
  logic          smp_valid_o;
  logic [OB-1:0] smp_data_o;
  logic [CW-1:0] smp_chan_o;
  logic [LW-1:0] fifo_level_o;
  logic          busy_o, cal_done_o, overflow_o, timeout_o;

  sar_adc_sequencer #(
    .RES_BITS(RES_BITS), .CHANNELS(CHANNELS), .OSR_LOG2_MAX(OSR_LOG2_MAX),
    .FIFO_DEPTH(FIFO_DEPTH), .CAL_CYCLES(CAL_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i(wb_clk_i), .nreset(nreset), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .cal_req_i(cal_req_i), .osr_log2_i(osr_log2_i),
    .chan_mask_i(chan_mask_i), .clr_i(clr_i), .adc_valid_i(adc_valid_i),
    .adc_result_i(adc_result_i), .adc_en_o(adc_en_o), .adc_cal_o(adc_cal_o),
    .adc_rstn_o(adc_rstn_o), .adc_chan_o(adc_chan_o), .smp_valid_o(smp_valid_o),
    .smp_ready_i(smp_ready_i), .smp_data_o(smp_data_o), .smp_chan_o(smp_chan_o),
    .fifo_level_o(fifo_level_o), .busy_o(busy_o), .cal_done_o(cal_done_o),
    .overflow_o(overflow_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int failures = 0;
  logic [CW+OB-1:0] exp_q[$];
  logic [CW+OB-1:0] m_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({adc_en_o, adc_cal_o, adc_rstn_o, adc_chan_o, smp_valid_o, smp_data_o,
                smp_chan_o, fifo_level_o, busy_o, cal_done_o, overflow_o, timeout_o});
  endfunction

  // Monitor: every accepted sample is compared against the scoreboard head.
  always @(negedge wb_clk_i) begin
    if (nreset && smp_valid_o && smp_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sample_unexpected: got chan=%0d data=0x%0h, expected none", smp_chan_o, smp_data_o);
      end else begin
        m_exp = exp_q.pop_front();
        if ({smp_chan_o, smp_data_o} !== m_exp) begin
          failures++;
          $display("FAIL sample: got chan=%0d data=0x%0h, expected chan=%0d data=0x%0h",
                   smp_chan_o, smp_data_o, m_exp[CW+OB-1:OB], m_exp[OB-1:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic start_run(input logic [CHANNELS-1:0] mask, input logic [OW-1:0] osr, input logic cont);
    @(posedge wb_clk_i); #1;
    chan_mask_i  = mask;
    osr_log2_i   = osr;
    continuous_i = cont;
    start_i      = 1'b1;
    tick(1);
    start_i      = 1'b0;
  endtask

  task automatic wait_en(output bit ok);
    int n;
    n = 0;
    @(negedge wb_clk_i);
    while (!adc_en_o && n < 50) begin
      n++;
      @(negedge wb_clk_i);
    end
    ok = adc_en_o;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_en: got adc_en_o=0 after 50 cycles, expected 1");
    end
  endtask

  // ADC model: raise adc_valid_i with a result for 'hold' clock edges while enabled.
  task automatic convert(input logic [RES_BITS-1:0] val, input int hold);
    bit ok;
    wait_en(ok);
    if (ok) begin
      @(posedge wb_clk_i); #1;
      adc_result_i = val;
      adc_valid_i  = 1'b1;
      tick(hold);
      adc_valid_i  = 1'b0;
    end
  endtask

  task automatic drain_wait(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    bit early;

    tick(3);
    check("reset_outputs", all_outs(), 32'd0);
    @(negedge wb_clk_i);
    nreset = 1'b1;
    tick(2);

    // Calibration, requested together with a start: calibration wins
    @(posedge wb_clk_i); #1;
    cal_req_i = 1'b1; start_i = 1'b1; chan_mask_i = 2'b01;
    tick(1);
    cal_req_i = 1'b0; start_i = 1'b0;
    n = 0; early = 1'b0;
    @(negedge wb_clk_i);
    while (adc_cal_o && n < 100) begin
      n++;
      if (cal_done_o) early = 1'b1;
      @(negedge wb_clk_i);
    end
    check("cal_length", 32'(n), 32'd16);
    check("cal_done_early", 32'(early), 32'd0);
    check("cal_done_pulse", 32'(cal_done_o), 32'd1);
    @(negedge wb_clk_i);
    check("cal_done_single", 32'(cal_done_o), 32'd0);
    check("cal_idle", 32'(busy_o), 32'd0);

    // One-shot, osr=0, both channels
    smp_ready_i = 1'b1;
    exp_q.push_back({1'b0, 14'h3FF0});
    exp_q.push_back({1'b1, 14'h0010});
    start_run(2'b11, 3'd0, 1'b0);
    convert(10'h3FF, 1);
    convert(10'h001, 1);
    tick(1);
    check("oneshot_busy_fall", 32'(busy_o), 32'd0);
    drain_wait("oneshot_drain");

    // osr=2 on channel 1, first result held high; mid-run input changes ignored
    exp_q.push_back({1'b1, 14'h0658});
    start_run(2'b10, 3'd2, 1'b0);
    chan_mask_i = 2'b01;
    osr_log2_i  = 3'd0;
    convert(10'd100, 3);
    convert(10'd101, 1);
    convert(10'd102, 1);
    convert(10'd103, 1);
    drain_wait("osr2_drain");
    tick(2);
    check("osr2_idle", 32'(busy_o), 32'd0);

    // osr request above maximum clamps to 4: sixteen results of 1 -> 16
    exp_q.push_back({1'b0, 14'h0010});
    start_run(2'b01, 3'd7, 1'b0);
    for (int k = 0; k < 16; k++) convert(10'd1, 1);
    drain_wait("osr_clamp_drain");

    // Continuous with consumer stalled: fill, overflow, clear, drain
    smp_ready_i = 1'b0;
    start_run(2'b01, 3'd0, 1'b1);
    for (int v = 1; v <= 9; v++) begin
      if (v <= 8) exp_q.push_back({1'b0, 14'(v << 4)});
      convert(10'(v), 1);
      if (v == 8) begin
        tick(1);
        check("fifo_full_level", 32'(fifo_level_o), 32'd8);
        check("fifo_full_no_ovf", 32'(overflow_o), 32'd0);
      end
    end
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
    check("ovf_set", 32'(overflow_o), 32'd1);
    check("ovf_level", 32'(fifo_level_o), 32'd8);
    check("ovf_head", 32'({smp_chan_o, smp_data_o}), 32'h0010);
    check("ovf_stopped", 32'(busy_o), 32'd0);
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    check("ovf_clear", 32'(overflow_o), 32'd0);
    smp_ready_i = 1'b1;
    drain_wait("ovf_drain");
    tick(1);
    check("ovf_drain_level", 32'(fifo_level_o), 32'd0);

    // No conversion ever completes: timeout after 255 CONV cycles
    start_run(2'b01, 3'd0, 1'b0);
    wait_en(ok);
    n = 0;
    while (adc_en_o && n < 400) begin
      n++;
      @(negedge wb_clk_i);
    end
    check("timeout_cycles", 32'(n), 32'd255);
    check("timeout_flag", 32'(timeout_o), 32'd1);
    check("timeout_idle", 32'(busy_o), 32'd0);
    check("timeout_fifo", 32'(fifo_level_o), 32'd0);
    tick(1);
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    check("timeout_clear", 32'(timeout_o), 32'd0);

    // Abort mid-accumulation leaves no sample behind
    start_run(2'b10, 3'd2, 1'b0);
    convert(10'd50, 1);
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
    check("stop_idle", 32'(busy_o), 32'd0);
    tick(3);
    check("stop_no_sample", 32'(fifo_level_o), 32'd0);

    // Reset during CONV with a sample buffered
    smp_ready_i = 1'b0;
    exp_q.push_back({1'b0, 14'h1550});
    start_run(2'b01, 3'd0, 1'b0);
    convert(10'h155, 1);
    tick(2);
    check("pre_reset_level", 32'(fifo_level_o), 32'd1);
    start_run(2'b01, 3'd0, 1'b0);
    wait_en(ok);
    nreset = 1'b0;
    #1;
    check("reset_async", all_outs(), 32'd0);
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("reset_hold", all_outs(), 32'd0);
    check("reset_adc_rstn", 32'(adc_rstn_o), 32'd0);
    @(negedge wb_clk_i);
    nreset = 1'b1;
    exp_q.delete();
    tick(2);
    check("post_reset_busy", 32'(busy_o), 32'd0);
    check("post_reset_level", 32'(fifo_level_o), 32'd0);

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
